// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the ID/EX stage.
//   - ALU opcode constants driven on Operation.
//   - fwd_sel_e: operand source chosen by the forwarding unit.
//   - id_ex_t: the full set of fields held in the ID/EX register.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int REG_W  = 5;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_BEQ = 4'b1000;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: combinational operand-source selection for the EX stage.
//   ex_rs1/ex_rs2         source indices of the instruction in EX
//   mem_rd/mem_reg_write  destination tag of the instruction in MEM
//   wb_rd/wb_reg_write    destination tag of the instruction in WB
//   fwd_a/fwd_b           selected source for rs1/rs2 (MEM beats WB)
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR = 5
) (
    input  logic [REG_ADDR-1:0] ex_rs1,
    input  logic [REG_ADDR-1:0] ex_rs2,
    input  logic [REG_ADDR-1:0] mem_rd,
    input  logic                mem_reg_write,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic                wb_reg_write,
    output fwd_sel_e            fwd_a,
    output fwd_sel_e            fwd_b
);

    // x0 is hardwired zero, so a write tagged 0 never supplies a value.
    function automatic fwd_sel_e pick(input logic [REG_ADDR-1:0] rs);
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    assign fwd_a = pick(ex_rs1);
    assign fwd_b = pick(ex_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   ID side : id_valid/id_ready handshake, decoded indices, operands,
//             immediate, PC, ALU op and control bits.
//   Control : flush (kill EX), ex_stall (hold EX).
//   Bypass  : MEM/WB destination tags, enables and results.
//   ALU side: SrcA, SrcB, Operation.
//   EX/MEM  : ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
//             ex_store_data (forwarded rs2), ex_pc.
// Load-use hazards stall ID for one cycle and insert a bubble into EX.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     flush,
    input  logic                     ex_stall,
    input  logic [REG_ADDR-1:0]      mem_rd,
    input  logic [REG_ADDR-1:0]      wb_rd,
    input  logic                     mem_reg_write,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [DATA_WIDTH-1:0]    ex_pc
);

    id_ex_t                stage_p0;
    id_ex_t                id_entry;
    logic                  load_use;
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    fwd_sel_e              fwd_a;
    fwd_sel_e              fwd_b;

    // Bubble keeps the data fields; only control and tags are killed.
    function automatic id_ex_t make_bubble(input id_ex_t s);
        id_ex_t b;
        b           = s;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        b.mem_write = 1'b0;
        b.op        = '0;
        b.rd        = '0;
        return b;
    endfunction

    // ---- ID side: hazard detection and capture-time WB bypass ----
    assign load_use = stage_p0.valid && stage_p0.mem_read && (stage_p0.rd != '0) &&
                      ((stage_p0.rd == id_rs1) || (stage_p0.rd == id_rs2)) && id_valid;

    // Gated by reset so id_ready reads 0 while the stage is held in reset.
    assign id_ready = reset && !ex_stall && !load_use;

    // WB writes the register file in the same cycle ID reads it, so the
    // read data may be stale; take the WB result directly in that case.
    always_comb begin
        id_entry           = '0;
        id_entry.valid     = 1'b1;
        id_entry.reg_write = id_reg_write;
        id_entry.mem_read  = id_mem_read;
        id_entry.mem_write = id_mem_write;
        id_entry.alu_src   = id_alu_src;
        id_entry.op        = id_alu_op;
        id_entry.rd        = id_rd;
        id_entry.rs1       = id_rs1;
        id_entry.rs2       = id_rs2;
        id_entry.imm       = id_imm;
        id_entry.pc        = id_pc;
        id_entry.rs1_data  = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_result : id_rs1_data;
        id_entry.rs2_data  = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_result : id_rs2_data;
    end

    // ---- ID/EX register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stage_p0 <= '0;
        else if (flush)
            stage_p0 <= make_bubble(stage_p0);
        else if (ex_stall)
            stage_p0 <= stage_p0;
        else if (load_use)
            stage_p0 <= make_bubble(stage_p0);
        else if (id_valid)
            stage_p0 <= id_entry;
        else
            stage_p0 <= make_bubble(stage_p0);
    end

    // ---- EX side: zero-cycle forwarding into the ALU operands ----
    forward_unit #(
        .REG_ADDR      (REG_ADDR)
    ) u_forward_unit (
        .ex_rs1        (stage_p0.rs1),
        .ex_rs2        (stage_p0.rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    always_comb begin
        case (fwd_a)
            FWD_MEM: rs1_fwd = mem_result;
            FWD_WB:  rs1_fwd = wb_result;
            default: rs1_fwd = stage_p0.rs1_data;
        endcase
        case (fwd_b)
            FWD_MEM: rs2_fwd = mem_result;
            FWD_WB:  rs2_fwd = wb_result;
            default: rs2_fwd = stage_p0.rs2_data;
        endcase
    end

    assign SrcA          = rs1_fwd;
    assign SrcB          = stage_p0.alu_src ? stage_p0.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign Operation     = stage_p0.op;
    assign ex_valid      = stage_p0.valid;
    assign ex_reg_write  = stage_p0.reg_write;
    assign ex_mem_read   = stage_p0.mem_read;
    assign ex_mem_write  = stage_p0.mem_write;
    assign ex_rd         = stage_p0.rd;
    assign ex_pc         = stage_p0.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the ID/EX stage kept in plain variables.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic        flush, ex_stall;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_pc         (id_pc),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .mem_result    (mem_result),
        .wb_result     (wb_result),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .Operation     (Operation),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_rd         (ex_rd),
        .ex_store_data (ex_store_data),
        .ex_pc         (ex_pc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Model of the instruction currently in EX.
    logic        m_valid, m_rw, m_mr, m_mw, m_src;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_a, m_b, m_imm, m_pc;

    task automatic model_reset();
        {m_valid, m_rw, m_mr, m_mw, m_src} = '0;
        m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
        m_a = '0; m_b = '0; m_imm = '0; m_pc = '0;
    endtask

    task automatic model_bubble();
        {m_valid, m_rw, m_mr, m_mw} = '0;
        m_op = '0;
        m_rd = '0;
    endtask

    // Value a register read sees this cycle: newest in-flight writer wins.
    function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] latched);
        if (idx == 5'd0) return latched;
        if (mem_reg_write && mem_rd == idx) return mem_result;
        if (wb_reg_write && wb_rd == idx) return wb_result;
        return latched;
    endfunction

    function automatic logic model_hazard();
        return m_valid && m_mr && (m_rd != 0) && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    task automatic compare_model();
        logic [31:0] ea, eb;
        check_val("id_ready", id_ready, reset && !ex_stall && !model_hazard());
        check_val("ex_valid", ex_valid, m_valid);
        check_val("ex_reg_write", ex_reg_write, m_rw);
        check_val("ex_mem_read", ex_mem_read, m_mr);
        check_val("ex_mem_write", ex_mem_write, m_mw);
        check_val("Operation", Operation, m_op);
        check_val("ex_rd", ex_rd, m_rd);
        if (m_valid) begin
            ea = reg_value(m_rs1, m_a);
            eb = reg_value(m_rs2, m_b);
            check_val("SrcA", SrcA, ea);
            check_val("SrcB", SrcB, m_src ? m_imm : eb);
            check_val("ex_store_data", ex_store_data, eb);
            check_val("ex_pc", ex_pc, m_pc);
        end
    endtask

    // Advance one clock; the model applies the update rules to the inputs
    // that were present at the edge (they do not change until after it).
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else if (flush) model_bubble();
        else if (ex_stall) begin end
        else if (model_hazard()) model_bubble();
        else if (id_valid) begin
            m_valid = 1'b1; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
            m_src = id_alu_src; m_op = id_alu_op; m_rd = id_rd;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_imm = id_imm; m_pc = id_pc;
            m_a = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_result : id_rs1_data;
            m_b = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_result : id_rs2_data;
        end
        else model_bubble();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_alu_op = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0; ex_stall = 0; mem_rd = 0; wb_rd = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_result = 0; wb_result = 0;
    endtask

    task automatic rand_inputs();
        id_valid      = ($urandom_range(0, 3) != 0);
        id_rs1        = 5'($urandom_range(0, 7));
        id_rs2        = 5'($urandom_range(0, 7));
        id_rd         = 5'($urandom_range(0, 7));
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
        id_pc         = $urandom;
        id_alu_op     = 4'($urandom_range(0, 15));
        id_alu_src    = 1'($urandom_range(0, 1));
        id_reg_write  = 1'($urandom_range(0, 1));
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = 1'($urandom_range(0, 1));
        flush         = ($urandom_range(0, 15) == 0);
        ex_stall      = ($urandom_range(0, 5) == 0);
        mem_rd        = 5'($urandom_range(0, 7));
        wb_rd         = 5'($urandom_range(0, 7));
        mem_reg_write = 1'($urandom_range(0, 1));
        wb_reg_write  = 1'($urandom_range(0, 1));
        mem_result    = $urandom;
        wb_result     = $urandom;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        #2;
        compare_model();
        check_val("reset SrcA", SrcA, 32'h0);
        check_val("reset id_ready", id_ready, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic capture: ADD 5, 7
        idle(); id_valid = 1; id_alu_op = 4'b0010; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
        id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1;
        #1 compare_model(); tick();
        idle(); #1 compare_model();
        check_val("basic SrcA", SrcA, 32'd5);
        check_val("basic SrcB", SrcB, 32'd7);
        check_val("basic Operation", Operation, 32'h2);
        check_val("basic ex_valid", ex_valid, 32'h1);

        // MEM over WB priority, then WB alone
        idle(); id_valid = 1; id_rs1 = 3; id_rs2 = 6; id_rs1_data = 32'hAA; id_alu_op = 4'b0010;
        #1 compare_model(); tick();
        idle(); ex_stall = 1; mem_rd = 3; mem_reg_write = 1; mem_result = 32'h11;
        wb_rd = 3; wb_reg_write = 1; wb_result = 32'h22;
        #1 compare_model();
        check_val("fwd mem over wb", SrcA, 32'h11);
        mem_reg_write = 0;
        #1 compare_model();
        check_val("fwd wb", SrcA, 32'h22);
        tick();

        // x0 never forwarded
        idle(); id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h55; mem_reg_write = 1; wb_reg_write = 1;
        mem_result = 32'h11; wb_result = 32'h22;
        #1 compare_model(); tick();
        id_valid = 0; ex_stall = 1;
        #1 compare_model();
        check_val("x0 SrcA", SrcA, 32'h55);
        tick();

        // Load-use: LW x5 then ADD using x5
        idle(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5; id_rs1 = 1;
        #1 compare_model(); tick();
        idle(); id_valid = 1; id_rs1 = 5; id_rs2 = 2; id_rs1_data = 32'h123; id_alu_op = 4'b0010; id_rd = 6;
        #1 compare_model();
        check_val("loaduse id_ready", id_ready, 32'h0);
        tick();
        #1 compare_model();
        check_val("loaduse bubble", ex_valid, 32'h0);
        check_val("loaduse ready again", id_ready, 32'h1);
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'h40;
        #1 compare_model(); tick();
        #1 compare_model();
        check_val("loaduse captured", ex_valid, 32'h1);
        check_val("loaduse fwd SrcA", SrcA, 32'h40);

        // Stall for 3 cycles, then flush together with stall
        idle(); id_valid = 1; id_rs1 = 2; id_rs1_data = 32'h77; id_alu_op = 4'b0011;
        #1 compare_model(); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); ex_stall = 1; id_valid = 1; id_rs1 = 3; id_rs1_data = $urandom;
            #1 compare_model();
            check_val("stall id_ready", id_ready, 32'h0);
            check_val("stall SrcA held", SrcA, 32'h77);
            tick();
        end
        idle(); flush = 1; ex_stall = 1;
        #1 compare_model(); tick();
        idle(); #1 compare_model();
        check_val("flush+stall bubble", ex_valid, 32'h0);

        // Capture-time WB bypass
        idle(); id_valid = 1; id_rs2 = 4; id_rs2_data = 32'h01; wb_rd = 4; wb_reg_write = 1; wb_result = 32'h99;
        #1 compare_model(); tick();
        idle(); #1 compare_model();
        check_val("bypass store_data", ex_store_data, 32'h99);

        // Asynchronous reset in the middle of a stall
        idle(); id_valid = 1; id_rs1 = 1; id_rs1_data = 32'hDEAD; id_pc = 32'h100; id_reg_write = 1; id_rd = 7;
        #1 compare_model(); tick();
        idle(); ex_stall = 1; mem_rd = 3; mem_reg_write = 1; mem_result = 32'hFF;
        #1 check_val("pre-reset ex_valid", ex_valid, 32'h1);
        #2 reset = 1'b0;
        #1 model_reset();
        compare_model();
        check_val("async rst ex_valid", ex_valid, 32'h0);
        check_val("async rst SrcA", SrcA, 32'h0);
        check_val("async rst SrcB", SrcB, 32'h0);
        check_val("async rst ex_pc", ex_pc, 32'h0);
        check_val("async rst ex_rd", ex_rd, 32'h0);
        check_val("async rst id_ready", id_ready, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            rand_inputs();
            #1 compare_model();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. It registers one decoded instruction per cycle and forwards results from MEM and WB into the operands. It detects load-use hazards, stalls ID and inserts a bubble when needed. It drives `SrcA`, `SrcB` and `Operation` straight into the ALU and carries the control fields that EX/MEM needs.

## Interface
- `DATA_WIDTH`, 32: operand width.
- `OPCODE_LENGTH`, 4: ALU operation width.
- `REG_ADDR`, 5: register index width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_ready`  out  1  stage accepts the ID instruction this cycle.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR  source and destination indices.
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc`  in  DATA_WIDTH  register-file reads, immediate, PC.
- `id_alu_op`  in  OPCODE_LENGTH  ALU operation code.
- `id_alu_src`  in  1  1 selects `id_imm` for SrcB.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control fields.
- `flush`  in  1  kill the EX contents (taken branch).
- `ex_stall`  in  1  downstream busy; hold the EX contents.
- `mem_rd`, `wb_rd`  in  REG_ADDR  destinations in MEM and WB.
- `mem_reg_write`, `wb_reg_write`  in  1  MEM/WB write enables.
- `mem_result`, `wb_result`  in  DATA_WIDTH  forwardable values.
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands.
- `Operation`  out  OPCODE_LENGTH  ALU operation code.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  EX control.
- `ex_rd`  out  REG_ADDR  EX destination.
- `ex_store_data`, `ex_pc`  out  DATA_WIDTH  forwarded rs2 value and PC.

## Operation
- **Load-use hazard:** `ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid`.
- **Ready:** `id_ready = !ex_stall & !load_use`.
- **Register update priority**, highest first:
  - `reset`: all registered fields cleared.
  - `flush`: bubble.
  - `ex_stall`: hold.
  - `load_use`: bubble.
  - `id_valid`: capture the ID instruction.
  - otherwise: bubble.
- **Bubble:** `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` = 0; `Operation` = 4'b0000; `ex_rd` = 0.
- **Capture-time bypass:**
  - If `wb_reg_write & wb_rd!=0 & wb_rd==id_rs1`, latch `wb_result` as rs1; same rule for rs2.
  - This covers a register-file write and read landing in the same cycle.
- **EX forwarding** (combinational, per operand):
  - MEM when `mem_reg_write & mem_rd!=0 & mem_rd==ex_rs`.
  - Else WB under the same rule.
  - Else the latched value.
  - MEM beats WB.
- **Operand select:**
  - `SrcA` = forwarded rs1.
  - `SrcB` = latched imm if alu_src, else forwarded rs2.
  - `ex_store_data` = forwarded rs2, always.
- **x0:** index 0 is never forwarded or bypassed; the latched value passes through.

## Timing
- **Reset:** every output is 0, including `id_ready`.
  - Deassertion is synchronised by the parent.
  - After deassertion, `id_ready` follows its equation.
- **Latency:** an instruction accepted at edge N is visible on the ALU inputs after edge N, for one cycle unless stalled.
- **Forwarding:** combinational, zero-cycle; MEM/WB changes in a cycle reflect on `SrcA`/`SrcB` in that cycle.
- **Load-use:** exactly one bubble per hazard.
  - The next cycle, the load is in MEM, so the dependent instruction is captured and forwarded from MEM.
- **`flush` with `ex_stall`:** flush wins, and the EX contents become a bubble.
- **`flush` during a load-use stall:** the bubble is written and the hazard clears next cycle; `id_ready` is still 0 in the flush cycle.
- **Reset mid-stall:** the stage returns to the reset values immediately, asynchronously.

## Structure
- **Package `pipeline_pkg`:**
  - ALU opcode constants: `ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_XOR`=0011, `ALU_SUB`=0110, `ALU_BEQ`=1000.
  - `fwd_sel_e` enum: `FWD_REG`, `FWD_MEM`, `FWD_WB`.
  - `id_ex_t` packed struct holding the registered fields.
- **Sub-module `forward_unit`:** combinational; inputs ex_rs1/ex_rs2 and the MEM/WB tags; outputs two `fwd_sel_e` selects.
  - Instantiated once.
  - Hazard detection stays inline.

## Test plan
- **Basic capture:** ADD, rs1_data=5, rs2_data=7, alu_src=0, no hazards -> next cycle `SrcA`=5, `SrcB`=7, `Operation`=0010, `ex_valid`=1.
- **MEM-over-WB priority:** EX rs1=x3; `mem_rd`=3 with `mem_result`=0x11 and `wb_rd`=3 with `wb_result`=0x22 -> `SrcA`=0x11. Drop `mem_reg_write` -> `SrcA`=0x22. Set rs1=x0 with both tags 0 -> latched value.
- **Load-use:** LW x5 in EX; ID ADD with rs1=x5 -> `id_ready`=0 for one cycle and `ex_valid`=0 next. The cycle after, ADD is captured, and with `mem_result`=0x40 `SrcA`=0x40.
- **Stall/flush:** `ex_stall`=1 for 3 cycles -> outputs held and `id_ready`=0. `flush` together with `ex_stall` -> bubble next cycle.
- **Capture bypass:** `wb_rd`=4, `wb_result`=0x99, `id_rs2`=4, `id_rs2_data`=stale 0x01 -> next cycle `ex_store_data`=0x99 with no WB still active.
- **Async reset:** assert `reset`=0 mid-cycle with `ex_valid`=1 -> all outputs 0 before the next edge.
